// File: rtl/uart_tx.sv
// UART transmitter: serialises FIFO words at 16 baud ticks per bit, with
// configurable word length, parity, stop bits and line break.
//
// state  | meaning
// IDLE   | line high, waiting for a tick with a word available
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | stop bit(s), high; may chain straight into the next START
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       pop,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky,
    input  logic       set_break,
    output logic       tx,
    output logic       tx_busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state, state_n;
    logic [4:0] tick, tick_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shreg, shreg_n;
    logic [1:0] wls_q, wls_n;
    logic       stb_q, stb_n;
    logic       pen_q, pen_n;
    logic       par_q, par_n;
    logic       line_n;
    logic       load;

    logic [7:0] word_mask;
    logic [7:0] masked;
    logic       par_calc;
    logic [4:0] stop_last;
    logic [2:0] last_bit;

    // Parity is computed from the incoming word at load time, masked to the word length.
    always_comb begin
        word_mask = 8'hff >> (2'd3 - wls);
        masked    = fifo_dout & word_mask;
        par_calc  = sticky ? ~eps : (eps ? ^masked : ~^masked);
        stop_last = !stb_q ? 5'd15 : ((wls_q == 2'b00) ? 5'd23 : 5'd31);
        last_bit  = {1'b0, wls_q} + 3'd4;
    end

    always_comb begin
        state_n = state;
        tick_n  = tick;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        wls_n   = wls_q;
        stb_n   = stb_q;
        pen_n   = pen_q;
        par_n   = par_q;
        load    = 1'b0;
        if (baud_pulse && !rst) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) load = 1'b1;
                end
                START: begin
                    if (tick == 5'd15) begin
                        state_n = DATA;
                        tick_n  = 5'd0;
                        bit_n   = 3'd0;
                    end else begin
                        tick_n = tick + 5'd1;
                    end
                end
                DATA: begin
                    if (tick == 5'd15) begin
                        tick_n = 5'd0;
                        if (bit_cnt == last_bit) begin
                            state_n = pen_q ? PARITY : STOP;
                        end else begin
                            bit_n   = bit_cnt + 3'd1;
                            shreg_n = shreg >> 1;
                        end
                    end else begin
                        tick_n = tick + 5'd1;
                    end
                end
                PARITY: begin
                    if (tick == 5'd15) begin
                        state_n = STOP;
                        tick_n  = 5'd0;
                    end else begin
                        tick_n = tick + 5'd1;
                    end
                end
                STOP: begin
                    if (tick == stop_last) begin
                        tick_n = 5'd0;
                        if (!fifo_empty) load = 1'b1;
                        else             state_n = IDLE;
                    end else begin
                        tick_n = tick + 5'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (load) begin
                state_n = START;
                tick_n  = 5'd0;
                bit_n   = 3'd0;
                shreg_n = fifo_dout;
                wls_n   = wls;
                stb_n   = stb;
                pen_n   = pen;
                par_n   = par_calc;
            end
        end
        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shreg_n[0];
            PARITY:  line_n = par_n;
            default: line_n = 1'b1;
        endcase
    end

    assign pop     = load;
    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= 5'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            wls_q   <= 2'd0;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            wls_q   <= wls_n;
            stb_q   <= stb_n;
            pen_q   <= pen_n;
            par_q   <= par_n;
            tx      <= set_break ? 1'b0 : line_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frame formats with hand-computed line
// patterns, plus back-to-back, break and mid-frame reset sequences.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst, baud_pulse, fifo_empty;
    logic [7:0] fifo_dout;
    logic       pop;
    logic [1:0] wls;
    logic       stb, pen, eps, sticky, set_break;
    logic       tx, tx_busy;

    uart_tx dut (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .pop(pop), .wls(wls), .stb(stb), .pen(pen),
        .eps(eps), .sticky(sticky), .set_break(set_break), .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // vec: line value of each 16-pulse bit slot in send order (start, data, parity);
    // nb: number of such slots; stop: stop-bit length in pulses.
    typedef struct {
        logic [1:0]  wls;
        logic        stb, pen, eps, sticky;
        logic [7:0]  data;
        logic [11:0] vec;
        int          nb;
        int          stop;
    } vec_t;

    vec_t       tbl[12];
    logic [7:0] q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (q.size() == 0);
        fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        q.push_back(d);
        drive_fifo();
    endtask

    task automatic apply_cfg(input int i);
        wls = tbl[i].wls; stb = tbl[i].stb; pen = tbl[i].pen;
        eps = tbl[i].eps; sticky = tbl[i].sticky;
    endtask

    task automatic scramble();
        wls = ~wls; stb = ~stb; pen = ~pen; eps = ~eps; sticky = ~sticky;
    endtask

    function automatic logic exp_tx(input int i, input int k);
        if (k < tbl[i].nb * 16) return tbl[i].vec[k / 16];
        return 1'b1;
    endfunction

    // One baud tick with an idle clock before it; returns the pop seen during the tick.
    task automatic pulse(output logic p);
        @(negedge clk);
        @(negedge clk);
        baud_pulse = 1'b1;
        #1 p = pop;
        @(negedge clk);
        baud_pulse = 1'b0;
        if (p && q.size() != 0) void'(q.pop_front());
        drive_fifo();
    endtask

    task automatic frame_body(input int i, input bit skip0, input bit brk, input int last_k);
        int   t;
        int   stop_k;
        logic p;
        t      = tbl[i].nb * 16 + tbl[i].stop;
        stop_k = (last_k < 0) ? t - 1 : last_k;
        for (int k = skip0 ? 1 : 0; k <= stop_k; k++) begin
            if (brk && k == 40) begin
                @(negedge clk); set_break = 1'b1;
                @(negedge clk); chk("break_assert_tx", tx, 0);
            end
            if (brk && k == 61) begin
                @(negedge clk); set_break = 1'b0;
                @(negedge clk); chk("break_release_tx", tx, exp_tx(i, k - 1));
            end
            pulse(p);
            chk($sformatf("pop row%0d k%0d", i, k), p, (k == 0));
            chk($sformatf("tx row%0d k%0d", i, k), tx,
                (brk && k >= 40 && k < 61) ? 1'b0 : exp_tx(i, k));
            chk($sformatf("busy row%0d k%0d", i, k), tx_busy, 1);
            if (k == 0) scramble();
        end
    endtask

    task automatic end_frame(input string name, input logic e_pop, input logic e_tx, input logic e_busy);
        logic p;
        pulse(p);
        chk({name, "_pop"}, p, e_pop);
        chk({name, "_tx"}, tx, e_tx);
        chk({name, "_busy"}, tx_busy, e_busy);
    endtask

    task automatic run_single(input int i);
        apply_cfg(i);
        push(tbl[i].data);
        frame_body(i, 1'b0, 1'b0, -1);
        end_frame($sformatf("end row%0d", i), 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic p;
        //            wls   stb   pen   eps   stk   data   vec      nb  stop
        tbl[0]  = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 12'h14A, 9,  16};
        tbl[1]  = '{2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h35, 12'h06A, 9,  16};
        tbl[2]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h13, 12'h026, 6,  24};
        tbl[3]  = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2A, 12'h054, 8,  32};
        tbl[4]  = '{2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 12'h1FE, 10, 16};
        tbl[5]  = '{2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 12'h200, 10, 16};
        tbl[6]  = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hE1, 12'h042, 7,  16};
        tbl[7]  = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 12'h0AA, 9,  16};
        tbl[8]  = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 12'h01E, 9,  16};
        tbl[9]  = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 12'h102, 10, 32};
        tbl[10] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 12'h078, 9,  16};
        tbl[11] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 12'h0B4, 9,  16};

        rst = 1'b1; baud_pulse = 1'b0; set_break = 1'b0;
        apply_cfg(0);
        drive_fifo();
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_pop", pop, 0);
        rst = 1'b0;

        for (int n = 0; n < 4; n++) begin
            pulse(p);
            chk("idle_empty_pop", p, 0);
            chk("idle_tx", tx, 1);
            chk("idle_busy", tx_busy, 0);
        end

        for (int i = 0; i < 7; i++) run_single(i);
        run_single(9);

        // Two queued words: second start bit on the tick that ends the first stop bit.
        apply_cfg(7);
        push(tbl[7].data);
        push(tbl[8].data);
        frame_body(7, 1'b0, 1'b0, -1);
        apply_cfg(8);
        end_frame("chain_second_start", 1'b1, 1'b0, 1'b1);
        frame_body(8, 1'b1, 1'b0, -1);
        end_frame("chain_end", 1'b0, 1'b1, 1'b0);

        // Break in the middle of the data bits.
        apply_cfg(11);
        push(tbl[11].data);
        frame_body(11, 1'b0, 1'b1, -1);
        end_frame("break_end", 1'b0, 1'b1, 1'b0);

        // Reset during data bit 3, with another word waiting and a tick present.
        apply_cfg(0);
        push(tbl[0].data);
        frame_body(0, 1'b0, 1'b0, 70);
        push(tbl[10].data);
        @(negedge clk);
        rst = 1'b1;
        baud_pulse = 1'b1;
        #1;
        chk("midreset_tx", tx, 1);
        chk("midreset_busy", tx_busy, 0);
        chk("midreset_pop", pop, 0);
        @(negedge clk);
        baud_pulse = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("postreset_pop", pop, 0);
            chk("postreset_busy", tx_busy, 0);
            chk("postreset_tx", tx, 1);
        end
        apply_cfg(10);
        frame_body(10, 1'b0, 1'b0, -1);
        end_frame("postreset_end", 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
